// File: rtl/phy_read_capture_ctrl_if.sv
// Capture-side beat bus and Read Buffer stream bus of phy_read_capture_ctrl.
// "master" drives beats and accepts the stream; "slave" is the capture block.
interface phy_read_capture_ctrl_if #(
    parameter int MEM_DATAWIDTH = 64
);
    logic                         burst_start;
    logic                         burst_chop;
    logic                         in_valid;
    logic [MEM_DATAWIDTH-1:0]     in_data;
    logic [MEM_DATAWIDTH/8-1:0]   in_dbi_n;
    logic [MEM_DATAWIDTH-1:0]     out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;

    modport master (
        output burst_start, burst_chop, in_valid, in_data, in_dbi_n, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  burst_start, burst_chop, in_valid, in_data, in_dbi_n, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/phy_read_capture_ctrl.sv
// DDR4 read-data capture: frames DQS beats into BL8/BC4 bursts, buffers them, streams out with LAST.
// Latency: beat visible on out_* one cycle after capture; read_ack one cycle after the last beat.
// Backpressure: out_ready stalls the FWFT head; a full FIFO drops beats (overflow_err). PHY_READ_DBI_EN enables DBI inversion.
module phy_read_capture_ctrl #(
    parameter int PHY_CHANNEL   = 0,
    parameter int MEM_DATAWIDTH = 64,
    parameter int FIFO_DEPTH    = 32,
    parameter int BURST_LENGTH  = 8,
    parameter int DESC_DEPTH    = 4
) (
    input  logic                          clk2x,
    input  logic                          rst,
    phy_read_capture_ctrl_if.slave        bus,
    output logic                          read_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_err,
    output logic                          protocol_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);
    localparam int BW = $clog2(BURST_LENGTH) + 1;
    localparam logic [BW-1:0] LEN_FULL  = BW'(BURST_LENGTH);
    localparam logic [BW-1:0] LEN_CHOP  = BW'(BURST_LENGTH / 2);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [DW:0]   DESC_FULL = (DW+1)'(DESC_DEPTH);
    localparam int unused_chan = PHY_CHANNEL;

    typedef enum logic {ST_IDLE, ST_CAPTURE} state_t;

    logic [MEM_DATAWIDTH-1:0] mem_q      [FIFO_DEPTH];
    logic [BW-1:0]            desc_len_q [DESC_DEPTH];

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [BW-1:0]  wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d, cur_len_q, cur_len_d;
    logic [DW-1:0]  dwr_ptr_q, dwr_ptr_d, drd_ptr_q, drd_ptr_d;
    logic [DW:0]    dcnt_q, dcnt_d;
    logic           read_ack_q, read_ack_d, ovf_q, ovf_d, prot_q, prot_d;

    logic                     fifo_full, desc_full, head_active, out_vld, out_lst;
    logic                     pop, desc_pop, beat, push, drop, start_ok;
    logic [BW-1:0]            head_len;
    logic [DW-1:0]            dtail_ptr;
    logic [MEM_DATAWIDTH-1:0] wr_data;

    always_comb begin
        wr_data = bus.in_data;
`ifdef PHY_READ_DBI_EN
        for (int i = 0; i < MEM_DATAWIDTH/8; i++) begin
            if (!bus.in_dbi_n[i]) wr_data[i*8 +: 8] = ~bus.in_data[i*8 +: 8];
        end
`endif
    end

`ifdef PHY_READ_DBI_EN
`else
    logic unused_dbi;
    assign unused_dbi = ^bus.in_dbi_n;
`endif

    assign fifo_full   = (level_q == LVL_FULL);
    assign desc_full   = (dcnt_q == DESC_FULL);
    assign head_len    = desc_len_q[drd_ptr_q];
    assign dtail_ptr   = dwr_ptr_q - DW'(1);
    assign head_active = (state_q == ST_CAPTURE) && (dcnt_q == (DW+1)'(1));
    assign out_vld     = (level_q != '0);
    assign out_lst     = out_vld && (dcnt_q != '0) && (head_len != '0) &&
                         (rd_beat_q == head_len - 1'b1);
    assign pop         = out_vld && bus.out_ready;
    // A burst whose every beat was dropped owns no data; retire its descriptor once capture is done.
    assign desc_pop    = (pop && out_lst) ||
                         ((dcnt_q != '0) && (head_len == '0) && !head_active);
    assign beat        = (state_q == ST_CAPTURE) && bus.in_valid;
    assign push        = beat && !fifo_full;
    assign drop        = beat && fifo_full;
    assign start_ok    = (state_q == ST_IDLE) && bus.burst_start && !desc_full;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        wr_beat_d  = wr_beat_q;
        rd_beat_d  = rd_beat_q;
        cur_len_d  = cur_len_q;
        dwr_ptr_d  = dwr_ptr_q;
        drd_ptr_d  = drd_ptr_q;
        dcnt_d     = dcnt_q;
        read_ack_d = 1'b0;
        ovf_d      = ovf_q || drop;
        prot_d     = prot_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.burst_start) begin
                    if (!desc_full) begin
                        state_d   = ST_CAPTURE;
                        wr_beat_d = '0;
                        cur_len_d = bus.burst_chop ? LEN_CHOP : LEN_FULL;
                    end else begin
                        prot_d = 1'b1;
                    end
                end
                if (bus.in_valid) prot_d = 1'b1;
            end
            default: begin
                if (bus.burst_start) prot_d = 1'b1;
                if (bus.in_valid) begin
                    wr_beat_d = wr_beat_q + 1'b1;
                    if (wr_beat_q == cur_len_q - 1'b1) begin
                        state_d    = ST_IDLE;
                        read_ack_d = 1'b1;
                    end
                end
            end
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_beat_d = out_lst ? '0 : rd_beat_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (start_ok) dwr_ptr_d = dwr_ptr_q + 1'b1;
        if (desc_pop) drd_ptr_d = drd_ptr_q + 1'b1;
        case ({start_ok, desc_pop})
            2'b10:   dcnt_d = dcnt_q + 1'b1;
            2'b01:   dcnt_d = dcnt_q - 1'b1;
            default: dcnt_d = dcnt_q;
        endcase
    end

    always_ff @(posedge clk2x or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_beat_q  <= '0;
            rd_beat_q  <= '0;
            cur_len_q  <= '0;
            dwr_ptr_q  <= '0;
            drd_ptr_q  <= '0;
            dcnt_q     <= '0;
            read_ack_q <= 1'b0;
            ovf_q      <= 1'b0;
            prot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_beat_q  <= wr_beat_d;
            rd_beat_q  <= rd_beat_d;
            cur_len_q  <= cur_len_d;
            dwr_ptr_q  <= dwr_ptr_d;
            drd_ptr_q  <= drd_ptr_d;
            dcnt_q     <= dcnt_d;
            read_ack_q <= read_ack_d;
            ovf_q      <= ovf_d;
            prot_q     <= prot_d;
        end
    end

    // Storage is deliberately not reset; level/pointers alone define validity.
    always_ff @(posedge clk2x) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Dropped beats shrink the active burst's descriptor so the reader frames on stored beats.
    always_ff @(posedge clk2x) begin
        if (start_ok) desc_len_q[dwr_ptr_q] <= bus.burst_chop ? LEN_CHOP : LEN_FULL;
        else if (drop && desc_len_q[dtail_ptr] != '0)
            desc_len_q[dtail_ptr] <= desc_len_q[dtail_ptr] - 1'b1;
    end

    assign bus.out_valid = out_vld;
    assign bus.out_last  = out_lst;
    assign bus.out_data  = out_vld ? mem_q[rd_ptr_q] : '0;
    assign read_ack      = read_ack_q;
    assign fifo_level    = level_q;
    assign overflow_err  = ovf_q;
    assign protocol_err  = prot_q;
endmodule

// File: doc/phy_read_capture_ctrl.md
# phy_read_capture_ctrl

Parametrised DDR4 READ-data capture block in the PHYController backend. It runs entirely in the clk2x (DQ-sampling) domain and frames incoming DQS-qualified beats into bursts of BL8 or BC4, which the PHYController selects per burst. Beats are buffered in a pointer-managed FIFO with a full/empty-aware occupancy count. The block emits one ACK per completed burst and streams beats toward the Read Buffer over a valid/ready handshake, with burst-exact LAST.

## Interface
Parameters:
- PHY_CHANNEL, 0, channel index (used only in debug display text)
- MEM_DATAWIDTH, 64, DQ width in bits; multiple of 8
- FIFO_DEPTH, 32, data FIFO entries; power of two, at least 2*BURST_LENGTH
- BURST_LENGTH, 8, full burst length in beats; chopped burst is BURST_LENGTH/2
- DESC_DEPTH, 4, burst-descriptor FIFO entries; power of two

Ports:
- clk2x  in  1  capture/stream clock
- rst  in  1  reset, asynchronous, active-low
- burst_start  in  1  single-cycle pulse that opens a burst
- burst_chop  in  1  sampled with burst_start; 1 = BC4, 0 = full burst
- in_valid  in  1  DQS-qualified beat strobe
- in_data  in  MEM_DATAWIDTH  DQ beat
- in_dbi_n  in  MEM_DATAWIDTH/8  per-byte DBI, active-low
- read_ack  out  1  one-cycle pulse per completed burst
- out_data  out  MEM_DATAWIDTH  head-of-FIFO beat
- out_valid  out  1  head beat present
- out_ready  in  1  Read Buffer accepts
- out_last  out  1  head beat is final beat of its burst
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied data entries
- overflow_err  out  1  sticky; a beat was dropped because the FIFO was full
- protocol_err  out  1  sticky; a framing violation occurred

## Operation
- Write FSM states:
  - IDLE: burst_start with descriptor FIFO not full → push descriptor {chop}, wr_beat=0, go to CAPTURE. burst_start with descriptor FIFO full → ignored, protocol_err=1.
  - CAPTURE: each in_valid writes in_data at wr_ptr and increments wr_beat. On the beat where wr_beat==len-1 (len = chop ? BURST_LENGTH/2 : BURST_LENGTH), return to IDLE and pulse read_ack on the next cycle.
- in_valid in IDLE (including the burst_start cycle itself) → beat dropped, protocol_err=1.
- burst_start in CAPTURE → ignored, protocol_err=1.
- in_valid while FIFO full, judged on the pre-edge count with no same-cycle pop bypass → beat dropped, overflow_err=1. wr_beat still advances so burst framing and read_ack timing are preserved.
- Read side is first-word-fall-through:
  - out_valid = (fifo_level != 0); out_data = FIFO[rd_ptr].
  - A pop occurs when out_valid & out_ready.
  - rd_beat counts beats against the head descriptor; out_last = out_valid & (rd_beat == head len - 1).
  - A pop with out_last pops the descriptor and clears rd_beat.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fifo_level changes by +1 on push only, -1 on pop only, and stays unchanged on simultaneous push and pop.
- A burst whose beats were dropped on overflow still pops its descriptor after the stored beat count. Bench checks framing only in non-overflow runs.
- Reset (asynchronous, at any time, including mid-burst): FSM=IDLE; pointers, counters and level=0; read_ack=0, out_valid=0, out_last=0, out_data=0; overflow_err=0, protocol_err=0. FIFO contents are not cleared.

## Timing
- Beat written at edge N → out_valid=1 from edge N onward (one-cycle write-to-read latency).
- Last beat at edge N → read_ack high for the cycle N..N+1 only.
- Pops can sustain one per cycle. out_data is held stable while out_valid & !out_ready.
- Error flags set at the edge of the offending cycle and hold until reset.

## Configuration
- PHY_READ_DBI_EN defined: before storage, byte lane i of in_data is inverted when in_dbi_n[i]==0.
- PHY_READ_DBI_EN undefined: in_dbi_n is ignored and data is stored unmodified. The port remains present.

## Test plan
- BL8 burst: burst_start(chop=0), 8 consecutive beats 0x0..0x7, out_ready=1 → read_ack one pulse after beat 7; out_data 0..7 in order; out_last only on 0x7; fifo_level returns to 0.
- Mixed bursts: BC4 then BL8 back-to-back, out_ready=0 until both are captured → fifo_level=12; after draining, out_last on the 4th and the 12th beat; two read_ack pulses.
- Backpressure: out_ready toggles 1/0 during a BL8 drain → no beat lost or duplicated; out_data stable while stalled.
- Overflow: FIFO_DEPTH=16, four BL8 bursts with out_ready=0 → fifo_level=16, overflow_err=1 at beat 17, four read_ack pulses.
- Protocol: in_valid in IDLE, and burst_start during CAPTURE → protocol_err=1, fifo_level unchanged by the stray beat; rst low mid-burst → all outputs 0, next BL8 burst correct.
- DBI (macro on): in_data=0xFF..FF with in_dbi_n=0xFE → byte0 stored as 0x00, other bytes 0xFF; macro off → stored as 0xFF..FF.
